// File: rtl/shift_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// shift_seq_ctrl_pkg
//   Shared constants, opcode encodings, FSM state type and helper function
//   for the multi-cycle shift sequencer (shift_seq_ctrl).
//   No ports (package).
// ----------------------------------------------------------------------------
package shift_seq_ctrl_pkg;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   // Right shifts run through the left-shift stage on a bit-reversed operand.
   function automatic logic is_right(input logic [1:0] op);
      return (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/bit32_shift_left_01.sv
// ----------------------------------------------------------------------------
// bit32_shift_left_01
//   Single shift stage: c = b ? (a << 1) : a, zero fill at bit 0.
//   Ports:
//     a  in  32  operand
//     b  in  1   stage select (1 = shift by one)
//     c  out 32  result
// ----------------------------------------------------------------------------
module bit32_shift_left_01 (
   input  logic [31:0] a,
   input  logic        b,
   output logic [31:0] c
);

   assign c = b ? {a[30:0], 1'b0} : a;

endmodule

// File: rtl/shift_seq_ctrl.sv
// ----------------------------------------------------------------------------
// shift_seq_ctrl
//   Multi-cycle SLL/SRL/SRA sequencer: one bit32_shift_left_01 stage is
//   applied once per clock for shamt cycles. Right shifts bit-reverse the
//   operand on load and the result on finish; SRA of a negative operand is
//   done as ~((~x) >> n).
//   Ports:
//     clk     in   1   system clock, rising edge
//     rst     in   1   synchronous reset, active-high
//     start   in   1   request, sampled only in IDLE or DONE
//     op      in   2   00=SLL 01=SRL 10=SRA 11=reserved (acts as SLL)
//     shamt   in   5   shift amount 0..31
//     a_in    in   32  operand
//     busy    out  1   high while shifting
//     done    out  1   one-cycle pulse, result valid from this cycle on
//     result  out  32  shifted value, held until the next accepted start
// ----------------------------------------------------------------------------
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   a_in,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   state_t             state_q;
   logic [1:0]         op_q;
   logic               inv_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic [WIDTH-1:0]   w_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   result_q;

   // ---------------------------------------------------------------- load path
   logic               inv_load;
   logic [WIDTH-1:0]   pre_load;
   logic [WIDTH-1:0]   pre_rev;
   logic [WIDTH-1:0]   w_load;

   assign inv_load = (op == OP_SRA) && a_in[WIDTH-1];
   assign pre_load = inv_load ? ~a_in : a_in;

   // ---------------------------------------------------------------- stage
   logic [WIDTH-1:0]   w_next;

   bit32_shift_left_01 u_stage (
      .a (w_q),
      .b (1'b1),
      .c (w_next)
   );

   // ---------------------------------------------------------------- finish path
   // In SHIFT the final value is the stage output of the last shift cycle;
   // otherwise it is a shamt==0 start finishing straight from the loaded word.
   logic               fin_shift;
   logic [WIDTH-1:0]   fin_src;
   logic               fin_right;
   logic               fin_inv;
   logic [WIDTH-1:0]   fin_rev;
   logic [WIDTH-1:0]   fin_post;
   logic [WIDTH-1:0]   fin_result;

   assign fin_shift  = (state_q == S_SHIFT);
   assign fin_src    = fin_shift ? w_next : w_load;
   assign fin_right  = fin_shift ? is_right(op_q) : is_right(op);
   assign fin_inv    = fin_shift ? inv_q : inv_load;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_rev
         assign pre_rev[gi] = pre_load[WIDTH-1-gi];
         assign fin_rev[gi] = fin_src[WIDTH-1-gi];
      end
   endgenerate

   assign w_load     = is_right(op) ? pre_rev : pre_load;
   assign fin_post   = fin_right ? fin_rev : fin_src;
   assign fin_result = fin_inv ? ~fin_post : fin_post;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= 2'b00;
         inv_q    <= 1'b0;
         cnt_q    <= '0;
         w_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  op_q  <= op;
                  inv_q <= inv_load;
                  cnt_q <= shamt;
                  w_q   <= w_load;
                  if (shamt == '0) begin
                     state_q  <= S_DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     result_q <= fin_result;
                  end else begin
                     state_q <= S_SHIFT;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_SHIFT: begin
               w_q   <= w_next;
               cnt_q <= cnt_q - SHAMT_W'(1);
               if (cnt_q == SHAMT_W'(1)) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= fin_result;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [4:0]  shamt;
   logic [31:0] a_in;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   shift_seq_ctrl dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .shamt  (shamt),
      .a_in   (a_in),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  shamt;
      logic [31:0] a;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   // Behavioural reference: plain shift operators on the operand.
   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [4:0] n,
                                             input logic [31:0] a);
      case (o)
         2'b01:   return a >> n;
         2'b10:   return $unsigned($signed(a) >>> n);
         default: return a << n;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Launch one operation from IDLE/DONE; scrambles inputs while it runs to
   // show they are not re-sampled. Returns result, latency in cycles from
   // the start cycle, and number of busy cycles seen before done.
   task automatic run_op(input logic [1:0] o, input logic [4:0] n, input logic [31:0] a,
                         output logic [31:0] res, output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; op = o; shamt = n; a_in = a;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         op = 2'($urandom); shamt = 5'($urandom); a_in = $urandom;
         @(negedge clk);
         lat++;
      end
      res = result;
      if (!done) begin
         total++; bad++;
         $display("FAIL timeout: no done within 40 cycles (op=%0d shamt=%0d)", o, n);
      end
   endtask

   initial begin
      logic [31:0] res, exp;
      int lat, bcnt;

      vecs[0] = '{2'b00, 5'd4,  32'h0000_0001, 32'h0000_0010};
      vecs[1] = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001};
      vecs[2] = '{2'b10, 5'd4,  32'hF000_0000, 32'hFF00_0000};
      vecs[3] = '{2'b10, 5'd4,  32'h7000_0000, 32'h0700_0000};
      vecs[4] = '{2'b10, 5'd0,  32'h8000_0001, 32'h8000_0001};
      vecs[5] = '{2'b11, 5'd8,  32'h0000_00FF, 32'h0000_FF00};
      vecs[6] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
      vecs[7] = '{2'b01, 5'd1,  32'h1234_5678, 32'h091A_2B3C};
      vecs[8] = '{2'b00, 5'd31, 32'h8000_0001, 32'h8000_0000};

      rst = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; a_in = 32'd0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      rst = 1'b0;

      // ---------------- table vectors
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].op, vecs[i].shamt, vecs[i].a, res, lat, bcnt);
         check($sformatf("vec%0d result", i), res, vecs[i].exp);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].shamt) + 1);
         check($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].shamt));
         $display("vec%0d op=%0d shamt=%0d a=%h result=%h lat=%0d", i, vecs[i].op,
                  vecs[i].shamt, vecs[i].a, res, lat);
         @(negedge clk);
         check($sformatf("vec%0d done pulse width", i), 32'(done), 32'd0);
         check($sformatf("vec%0d result held", i), result, vecs[i].exp);
      end

      // ---------------- start pulsed during SHIFT is ignored
      @(negedge clk);
      start = 1'b1; op = 2'b00; shamt = 5'd10; a_in = 32'h0000_0001;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; op = 2'b01; shamt = 5'd2; a_in = 32'hFFFF_0000;
      @(negedge clk);
      start = 1'b0;
      lat = 4;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      check("ignore-start latency", 32'(lat), 32'd11);
      check("ignore-start result", result, 32'h0000_0400);
      $display("ignore-start result=%h lat=%0d", result, lat);

      // ---------------- back-to-back: start held in the DONE cycle
      start = 1'b1; op = 2'b10; shamt = 5'd3; a_in = 32'h8000_0010;
      @(negedge clk);
      start = 1'b0;
      check("b2b busy after DONE", 32'(busy), 32'd1);
      lat = 1;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
      check("b2b latency", 32'(lat), 32'd4);
      check("b2b result", result, 32'hF000_0002);
      $display("b2b result=%h lat=%0d", result, lat);
      // zero-shift back-to-back: DONE -> DONE
      start = 1'b1; op = 2'b01; shamt = 5'd0; a_in = 32'hCAFE_0001;
      @(negedge clk);
      start = 1'b0;
      check("b2b zero done", 32'(done), 32'd1);
      check("b2b zero result", result, 32'hCAFE_0001);
      $display("b2b-zero result=%h", result);

      // ---------------- rst mid-SHIFT
      @(negedge clk);
      start = 1'b1; op = 2'b00; shamt = 5'd20; a_in = 32'h0000_0003;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort result", result, 32'd0);
      lat = 0;
      for (int k = 0; k < 25; k++) begin
         if (done) lat++;
         @(negedge clk);
      end
      check("abort no done", 32'(lat), 32'd0);
      $display("abort result=%h spurious_done=%0d", result, lat);
      run_op(2'b00, 5'd2, 32'h0000_0005, res, lat, bcnt);
      check("post-abort result", res, 32'h0000_0014);
      check("post-abort latency", 32'(lat), 32'd3);

      // ---------------- random against behavioural model
      for (int i = 0; i < 1000; i++) begin
         logic [1:0]  ro;
         logic [4:0]  rn;
         logic [31:0] ra;
         ro = 2'($urandom);
         rn = 5'($urandom);
         ra = $urandom;
         if (i % 4 == 0) ra[31] = 1'b1;
         exp = ref_shift(ro, rn, ra);
         run_op(ro, rn, ra, res, lat, bcnt);
         check($sformatf("rand%0d result", i), res, exp);
         check($sformatf("rand%0d latency", i), 32'(lat), 32'(rn) + 1);
         $display("rand%0d op=%0d shamt=%0d a=%h result=%h exp=%h", i, ro, rn, ra, res, exp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
